tt_sweep_capture: RTL and testbench

- Sequential truth-table reader for a combinational N-input, M-output logic block.
- On start, drives every input combination 0..2^N_IN-1 onto the block under test and samples each function output.
- Assembles one minterm mask per function: mask bit i = function value at input index i.
- Returns all masks through a valid/ready result handshake; sits beside the combinational logic modules as their self-characterising companion.

---
 rtl/tt_pkg.sv | 22 ++
 rtl/tt_settle_cnt.sv | 34 +++
 rtl/tt_sweep_capture.sv | 178 +++++++++++++++++
 tb/tb_tt_sweep_capture.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweep capture block.
package tt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_HOLD   = 3'd4
  } tt_state_e;

  localparam int CNT_W = 4;

  function automatic int n_comb(input int n_in);
    return 32'sd1 << n_in;
  endfunction

  function automatic int slice_idx(input int f, input int i, input int n_c);
    return (f * n_c) + i;
  endfunction

endpackage

// File: rtl/tt_settle_cnt.sv
// Loadable down-counter used to time the settle window after each drive.
module tt_settle_cnt
  import tt_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q;

  // counter register: load wins over decrement, saturates at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != {W{1'b0}})) begin
      cnt_q <= cnt_q - W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign zero_o = (cnt_q == {W{1'b0}});
  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps all input combinations of a combinational block and captures one minterm mask per output.
// Optional golden compare of the captured masks is enabled with `define TT_GOLDEN_CHECK_EN.
module tt_sweep_capture
  import tt_pkg::*;
#(
  parameter int N_IN       = 3,
  parameter int N_FN       = 5,
  parameter int SETTLE_CYC = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic                           busy,
  output logic [N_IN-1:0]                drv_vec,
  input  logic [N_FN-1:0]                fn_in,
  output logic                           res_valid,
  input  logic                           res_ready,
`ifdef TT_GOLDEN_CHECK_EN
  input  logic [N_FN*n_comb(N_IN)-1:0]   exp_mask,
  output logic [N_FN-1:0]                mismatch,
  output logic                           any_mismatch,
`endif
  output logic [N_FN*n_comb(N_IN)-1:0]   res_mask
);

  localparam int N_COMB = n_comb(N_IN);
  localparam int MASK_W = N_FN * N_COMB;
  localparam int BIT_W  = $clog2(MASK_W);
  localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'(N_COMB - 1);
  localparam logic [N_IN:0] IDX_ONE  = (N_IN+1)'(1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);
  localparam logic NO_SETTLE = (SETTLE_CYC == 0);

  tt_state_e         state_q, state_d;
  logic [N_IN:0]     idx_q, idx_d;
  logic [N_IN-1:0]   drv_q, drv_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              cnt_load_s, cnt_dec_s, cnt_zero_s, cnt_last_s;
  logic [BIT_W-1:0]  bit_s;
`ifdef TT_GOLDEN_CHECK_EN
  logic [N_FN-1:0]   mm_q, mm_d;
  logic              any_q, any_d;
`endif

  tt_settle_cnt #(.W(CNT_W)) u_settle_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load_s),
    .load_val_i (SETTLE_LD),
    .dec_i      (cnt_dec_s),
    .zero_o     (cnt_zero_s),
    .last_o     (cnt_last_s)
  );

  // next-state and datapath updates for the sweep sequencer
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    drv_d      = drv_q;
    mask_d     = mask_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    bit_s      = {BIT_W{1'b0}};
`ifdef TT_GOLDEN_CHECK_EN
    mm_d  = mm_q;
    any_d = any_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRIVE;
          busy_d  = 1'b1;
          idx_d   = {(N_IN+1){1'b0}};
          mask_d  = {MASK_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        drv_d      = idx_q[N_IN-1:0];
        cnt_load_s = 1'b1;
        if (NO_SETTLE) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_dec_s = 1'b1;
        // a zero count only appears if the load was skipped; never stall on it
        if (cnt_last_s || cnt_zero_s) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        for (int f = 0; f < N_FN; f++) begin
          bit_s         = BIT_W'(slice_idx(f, int'(idx_q), N_COMB));
          mask_d[bit_s] = fn_in[f];
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_HOLD;
          valid_d = 1'b1;
`ifdef TT_GOLDEN_CHECK_EN
          for (int f = 0; f < N_FN; f++) begin
            mm_d[f] = (mask_d[f*N_COMB +: N_COMB] != exp_mask[f*N_COMB +: N_COMB]);
          end
          any_d = |mm_d;
`endif
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = ST_DRIVE;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
`ifdef TT_GOLDEN_CHECK_EN
          mm_d  = {N_FN{1'b0}};
          any_d = 1'b0;
`endif
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = {(N_IN+1){1'b0}};
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= {(N_IN+1){1'b0}};
      drv_q   <= {N_IN{1'b0}};
      mask_q  <= {MASK_W{1'b0}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef TT_GOLDEN_CHECK_EN
      mm_q    <= {N_FN{1'b0}};
      any_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drv_q   <= drv_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef TT_GOLDEN_CHECK_EN
      mm_q    <= mm_d;
      any_q   <= any_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign drv_vec   = drv_q;
  assign res_valid = valid_q;
  assign res_mask  = mask_q;
`ifdef TT_GOLDEN_CHECK_EN
  assign mismatch     = mm_q;
  assign any_mismatch = any_q;
`endif

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Self-checking bench for tt_sweep_capture: directed and random truth tables vs. a lookup-table model.
module tb_tt_sweep_capture;

  localparam logic [39:0] DIR_MASK = 40'h00_66_F0_55_80;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic [2:0]  drv_vec;
  logic [4:0]  fn_in;
  logic        res_valid;
  logic        res_ready;
  logic [39:0] res_mask;
  logic [7:0]  lut [5];
  int          tests = 0;
  int          failed = 0;
`ifdef TT_GOLDEN_CHECK_EN
  logic [39:0] exp_mask;
  logic [4:0]  mismatch;
  logic        any_mismatch;
`endif

  always #5 clk = ~clk;

  // block under test modelled as one lookup table per function output
  always_comb begin
    fn_in = 5'b0;
    for (int f = 0; f < 5; f++) fn_in[f] = lut[f][drv_vec];
  end

  tt_sweep_capture dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .drv_vec      (drv_vec),
    .fn_in        (fn_in),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
`ifdef TT_GOLDEN_CHECK_EN
    .exp_mask     (exp_mask),
    .mismatch     (mismatch),
    .any_mismatch (any_mismatch),
`endif
    .res_mask     (res_mask)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one full sweep; edge 0 is the edge that accepts start
  task automatic run_sweep(input logic [39:0] exp, input int ready_wait, input bit early_ready,
                           input bit mid_start, input bit start_on_accept);
`ifdef TT_GOLDEN_CHECK_EN
    logic [4:0] exp_mm;
    for (int f = 0; f < 5; f++) exp_mm[f] = (exp_mask[f*8 +: 8] != exp[f*8 +: 8]);
`endif
    @(negedge clk);
    start     = 1'b1;
    res_ready = early_ready;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {63'b0, busy}, 64'd1);
    chk("valid_after_start", {63'b0, res_valid}, 64'd0);
    for (int j = 1; j <= 24; j++) begin
      start = (mid_start && (j == 5));
      @(negedge clk);
      chk("drv_sched", {61'b0, drv_vec}, 64'((j - 1) / 3));
      chk("valid_sched", {63'b0, res_valid}, 64'(j == 24));
    end
    start = 1'b0;
    chk("mask_at_valid", {24'b0, res_mask}, {24'b0, exp});
`ifdef TT_GOLDEN_CHECK_EN
    chk("mismatch", {59'b0, mismatch}, {59'b0, exp_mm});
    chk("any_mismatch", {63'b0, any_mismatch}, {63'b0, |exp_mm});
`endif
    for (int k = 0; k < ready_wait; k++) begin
      @(negedge clk);
      chk("hold_valid", {63'b0, res_valid}, 64'd1);
      chk("hold_mask", {24'b0, res_mask}, {24'b0, exp});
      chk("hold_busy", {63'b0, busy}, 64'd1);
    end
    res_ready = 1'b1;
    start     = start_on_accept;
    @(negedge clk);
    res_ready = 1'b0;
    start     = 1'b0;
    chk("accept_valid", {63'b0, res_valid}, 64'd0);
    chk("accept_busy", {63'b0, busy}, 64'd0);
    @(negedge clk);
    chk("idle_no_restart", {63'b0, busy}, 64'd0);
    chk("idle_drv_held", {61'b0, drv_vec}, 64'd7);
  endtask

  initial begin
    logic [2:0]  v;
    logic [39:0] exp;
    rst_n     = 1'b0;
    start     = 1'b0;
    res_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      lut[0][i] = v[2] & v[1] & v[0];
      lut[1][i] = ~v[0];
      lut[2][i] = v[2];
      lut[3][i] = v[1] ^ v[0];
      lut[4][i] = 1'b0;
    end
`ifdef TT_GOLDEN_CHECK_EN
    exp_mask = DIR_MASK;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_state", {22'b0, busy, res_valid, drv_vec, res_mask}, 64'd0);

    run_sweep(DIR_MASK, 0, 1'b0, 1'b0, 1'b0);
`ifdef TT_GOLDEN_CHECK_EN
    exp_mask = 40'h00_69_F0_55_80;
`endif
    run_sweep(DIR_MASK, 10, 1'b0, 1'b1, 1'b1);
`ifdef TT_GOLDEN_CHECK_EN
    exp_mask = DIR_MASK;
`endif
    run_sweep(DIR_MASK, 0, 1'b1, 1'b0, 1'b0);

    // abort a sweep while index 4 is driven
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    chk("pre_reset_drv", {61'b0, drv_vec}, 64'd4);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {22'b0, busy, res_valid, drv_vec, res_mask}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(DIR_MASK, 1, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int f = 0; f < 5; f++) lut[f] = 8'($urandom);
      exp = {lut[4], lut[3], lut[2], lut[1], lut[0]};
`ifdef TT_GOLDEN_CHECK_EN
      exp_mask = exp;
`endif
      run_sweep(exp, $urandom_range(0, 3), 1'b0, r[0], 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
